td4_control_unit: RTL
=====================

// Module: td4_control_unit
// PURPOSE
//   Instruction sequencer for the 4-bit TD4 CPU. It fetches 8-bit instructions
//   from program ROM over a req/ack handshake, decodes the opcode nibble and
//   drives the operand-select and register-load controls of the datapath
//   (A/B registers, output port, ALU adder). It also owns the PC and carry flag.
//   One instruction takes FETCH (>=1 cycle) + EXEC (1 cycle); supports free-run and single-step.
// PARAMETERS
//   PC_W     4   program counter / ROM address width; PC wraps modulo 2**PC_W
// PORTS
//   clk          in   1      system clock, all state on rising edge
//   rst_n        in   1      asynchronous active-low reset
//   run          in   1      1 = free-run; 0 = stop at next instruction boundary
//   step         in   1      in IDLE with run=0: execute exactly one instruction
//   rom_addr     out  PC_W   ROM address (= pc)
//   rom_req      out  1      fetch request, high throughout FETCH
//   rom_ack      in   1      ROM data valid this cycle
//   rom_data     in   8      instruction {op[3:0], imm[3:0]}
//   sel          out  2      operand select: 00 reg A, 01 reg B, 10 input port, 11 zero
//   imm          out  4      immediate to ALU adder (= ir[3:0])
//   alu_carry    in   1      adder carry-out for the current EXEC operands
//   ld_a/ld_b/ld_out out 1 each  load enables, at most one high, only in EXEC
//   carry_flag   out  1      registered carry
//   illegal_op   out  1      1-cycle pulse in EXEC for undefined opcode
//   pc           out  PC_W   program counter
//   busy         out  1      state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc=0, ir=8'h00, carry_flag=0, rom_req=0,
//     ld_*=0, illegal_op=0, sel=2'b11, imm=0. Reset mid-fetch drops rom_req at once.
//   States: IDLE -> FETCH when run|step. FETCH: rom_req=1, rom_addr=pc stable;
//     on rom_ack: ir<=rom_data, -> EXEC (zero-wait ROM: ack in first FETCH cycle).
//     EXEC (1 cycle): drive decode outputs, update pc/carry; -> FETCH if run else IDLE.
//   run dropped during FETCH/EXEC: current instruction completes, then IDLE.
//   step ignored outside IDLE; step with run=1 has no extra effect.
//   Outside EXEC: ld_*=0, illegal_op=0, sel=11; imm always = ir[3:0].
//   Decode (op = ir[7:4]) -> sel, load:
//     0000 ADD A,Im  00 ld_a | 0001 MOV A,B  01 ld_a | 0010 IN A  10 ld_a
//     0011 MOV A,Im  11 ld_a | 0100 MOV B,A  00 ld_b | 0101 ADD B,Im 01 ld_b
//     0110 IN B      10 ld_b | 0111 MOV B,Im 11 ld_b | 1001 OUT B  01 ld_out
//     1011 OUT Im    11 ld_out | 1110 JNC Im 11 none | 1111 JMP Im 11 none
//     other: sel 11, no load, illegal_op=1, otherwise NOP.
//   PC: JMP -> pc<=imm (zero-extended); JNC -> pc<=imm iff carry_flag==0
//     (value before this EXEC's update); else pc<=pc+1, wraps 2**PC_W-1 -> 0.
//   Carry: carry_flag<=alu_carry at end of every EXEC, incl. jumps and illegal.
//   rom_data/alu_carry sampled only on rom_ack in FETCH / in EXEC respectively.
// TESTING
//   1 reset, run=1, zero-wait ROM, rom[0]=8'h35 -> EXEC cycle 2: sel=11, imm=5,
//     ld_a=1 only; pc 0->1; next rom_req cycle 3 (2 cycles/instr).
//   2 rom[0]=8'h0F with alu_carry=1, rom[1]=8'hE7 -> no jump, pc=2; repeat with
//     alu_carry=0 -> pc=7; rom[x]=8'hF3 -> pc=3 regardless of carry.
//   3 rom_ack delayed 3 cycles -> rom_req high 4 cycles, rom_addr stable, ld_*=0.
//   4 pc=15 (PC_W=4) executing 8'h74 -> pc=0, ld_b=1, sel=11.
//   5 run=0, one-cycle step pulse -> exactly one FETCH+EXEC, then IDLE, busy=0;
//     step during FETCH ignored.
//   6 rom[0]=8'h8A -> illegal_op pulse 1 cycle, no ld_*, pc=1; rst_n low mid-FETCH
//     -> rom_req=0, pc=0 immediately.

Source files
------------

// File: rtl/td4_control_unit.sv
// td4_control_unit
//   Instruction sequencer for the 4-bit TD4 CPU.
//   - Fetches 8-bit instructions {op, imm} from program ROM using a req/ack handshake.
//   - Decodes the opcode and drives the datapath operand-select and load enables.
//   - Owns the program counter and the carry flag.
//   - Each instruction takes FETCH (one or more cycles) plus EXEC (exactly one cycle).
//   - Supports free-run and single-step.
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   run, step         free-run level; single-step request (only honoured in IDLE)
//   rom_addr/req      ROM address (= pc); request, held high for all of FETCH
//   rom_ack/data      ROM data-valid strobe; instruction byte
//   sel, imm          operand select (00 A, 01 B, 10 in-port, 11 zero); immediate (= ir[3:0])
//   alu_carry         adder carry-out, sampled during EXEC
//   ld_a/ld_b/ld_out  one-hot load enables, active only in EXEC
//   carry_flag        registered carry
//   illegal_op        EXEC pulse for an undefined opcode
//   pc, busy          program counter; high whenever the state is not IDLE
module td4_control_unit #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            step,
  output logic [PC_W-1:0] rom_addr,
  output logic            rom_req,
  input  logic            rom_ack,
  input  logic [7:0]      rom_data,
  output logic [1:0]      sel,
  output logic [3:0]      imm,
  input  logic            alu_carry,
  output logic            ld_a,
  output logic            ld_b,
  output logic            ld_out,
  output logic            carry_flag,
  output logic            illegal_op,
  output logic [PC_W-1:0] pc,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  state_t          state, state_nx;
  logic [7:0]      ir;
  logic            jmp, jnc;
  logic [PC_W-1:0] jmp_tgt;

  assign jmp_tgt  = PC_W'(ir[3:0]);
  assign imm      = ir[3:0];
  assign rom_addr = pc;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and decode.
  // The load enables and illegal_op are decoded from state directly, so an
  // asynchronous reset removes them immediately, with no wait for a clock edge.
  always_comb begin
    state_nx   = state;
    rom_req    = 1'b0;
    sel        = 2'b11;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_out     = 1'b0;
    illegal_op = 1'b0;
    jmp        = 1'b0;
    jnc        = 1'b0;
    unique case (state)
      IDLE:  if (run || step) state_nx = FETCH;
      FETCH: begin
        rom_req = 1'b1;
        if (rom_ack) state_nx = EXEC;
      end
      EXEC: begin
        state_nx = run ? FETCH : IDLE;
        unique case (ir[7:4])
          4'b0000: begin sel = 2'b00; ld_a   = 1'b1; end
          4'b0001: begin sel = 2'b01; ld_a   = 1'b1; end
          4'b0010: begin sel = 2'b10; ld_a   = 1'b1; end
          4'b0011: begin sel = 2'b11; ld_a   = 1'b1; end
          4'b0100: begin sel = 2'b00; ld_b   = 1'b1; end
          4'b0101: begin sel = 2'b01; ld_b   = 1'b1; end
          4'b0110: begin sel = 2'b10; ld_b   = 1'b1; end
          4'b0111: begin sel = 2'b11; ld_b   = 1'b1; end
          4'b1001: begin sel = 2'b01; ld_out = 1'b1; end
          4'b1011: begin sel = 2'b11; ld_out = 1'b1; end
          4'b1110: jnc = 1'b1;
          4'b1111: jmp = 1'b1;
          default: illegal_op = 1'b1;
        endcase
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ir <= 8'h00;
    else if (state == FETCH && rom_ack) ir <= rom_data;
  end

  // JNC tests carry_flag before this EXEC overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      carry_flag <= 1'b0;
    end else if (state == EXEC) begin
      carry_flag <= alu_carry;
      if (jmp || (jnc && !carry_flag)) pc <= jmp_tgt;
      else                             pc <= pc + 1'b1;
    end
  end

endmodule
